xem6010_template_project_core: RTL and testbench

//  Host-loopback template core for the XEM6010 board: 16-bit words pushed by the host pipe-in
//  are buffered in a FIFO and returned in order on the host pipe-out. Reports fill levels to
//  the host, shows the word count on the board LEDs and provides a single test loopback register.

---
 rtl/xem6010_template_project_core_pkg.sv | 13 +
 rtl/xem6010_template_project_core_fifo_sync.sv | 68 ++++++
 rtl/xem6010_template_project_core.sv | 98 +++++++++
 tb/tb_xem6010_template_project_core.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xem6010_template_project_core_pkg.sv
// Shared constants and helpers for the XEM6010 host-loopback template core.
package xem6010_template_project_core_pkg;

    localparam int MEM_DATA_WIDTH  = 16;
    localparam int HOST_WORD_WIDTH = 16;
    localparam int LED_WIDTH       = 8;

    // Board LEDs are active-low, so a lit LED marks a set bit of the word count.
    function automatic logic [LED_WIDTH-1:0] led_pattern(input logic [HOST_WORD_WIDTH-1:0] count);
        return ~count[LED_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/xem6010_template_project_core_fifo_sync.sv
// Single-clock first-word-fall-through FIFO with an explicit occupancy counter.
module fifo_sync
    import xem6010_template_project_core_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wr_fire;
    logic                  rd_fire;

    // A read against an empty FIFO is dropped even if a write lands the same cycle.
    always_comb begin
        full     = (count_q == CNT_DEPTH);
        empty    = (count_q == '0);
        wr_fire  = wr_en && !full;
        rd_fire  = rd_en && !empty;
        wr_ptr_d = wr_fire ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        rd_data  = empty ? '0 : mem_q[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_fire && !rst) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/xem6010_template_project_core.sv
// Host-loopback core: pipe-in words go through a FIFO back to pipe-out, with fill levels,
// an LED word count and a single host-visible test register.
module xem6010_template_project_core
    import xem6010_template_project_core_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 4
) (
    input  logic                       ti_clk,
    input  logic                       ti_rst_soft,
    input  logic                       a_rst_hard,
    input  logic                       s_clk,
    output logic [LED_WIDTH-1:0]       a_led,
    output logic [HOST_WORD_WIDTH-1:0] ti_in_available,
    input  logic                       ti_in_data_en,
    input  logic [HOST_WORD_WIDTH-1:0] ti_in_data,
    output logic [HOST_WORD_WIDTH-1:0] ti_out_available,
    input  logic                       ti_out_data_en,
    output logic [HOST_WORD_WIDTH-1:0] ti_out_data,
    input  logic                       ti_in_test_en,
    input  logic [HOST_WORD_WIDTH-1:0] ti_in_test,
    input  logic                       ti_out_test_en,
    output logic [HOST_WORD_WIDTH-1:0] ti_out_test
);

    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam logic [HOST_WORD_WIDTH-1:0] DEPTH_WORD = DEPTH[HOST_WORD_WIDTH-1:0];

    logic                       rst_meta_q, rst_meta_d;
    logic                       rst_sync_q, rst_sync_d;
    logic                       rst;
    logic [HOST_WORD_WIDTH-1:0] in_avail_q, in_avail_d;
    logic [HOST_WORD_WIDTH-1:0] out_avail_q, out_avail_d;
    logic [LED_WIDTH-1:0]       led_q, led_d;
    logic [HOST_WORD_WIDTH-1:0] test_q, test_d;
    logic [MEM_ADDR_WIDTH:0]    fifo_count;
    logic [HOST_WORD_WIDTH-1:0] count_word;
    logic [MEM_DATA_WIDTH-1:0]  fifo_rd_data;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       unused_inputs;

    // s_clk is a board pin kept only so the port list matches the board top; the test
    // read strobe has no side effect on the register.
    assign unused_inputs = &{1'b0, s_clk, ti_out_test_en, fifo_full, fifo_empty};

    fifo_sync #(
        .ADDR_WIDTH (MEM_ADDR_WIDTH),
        .DATA_WIDTH (MEM_DATA_WIDTH)
    ) u_fifo (
        .clk     (ti_clk),
        .rst     (rst),
        .wr_en   (ti_in_data_en),
        .wr_data (ti_in_data),
        .rd_en   (ti_out_data_en),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        rst_meta_d  = a_rst_hard;
        rst_sync_d  = rst_meta_q;
        rst         = ti_rst_soft | rst_sync_q;
        count_word  = HOST_WORD_WIDTH'(fifo_count);
        in_avail_d  = DEPTH_WORD - count_word;
        out_avail_d = count_word;
        led_d       = led_pattern(count_word);
        test_d      = ti_in_test_en ? ti_in_test : test_q;
    end

    // The button synchroniser itself is never reset; it only carries the asynchronous request.
    always_ff @(posedge ti_clk) begin
        rst_meta_q <= rst_meta_d;
        rst_sync_q <= rst_sync_d;
    end

    always_ff @(posedge ti_clk) begin
        if (rst) begin
            in_avail_q  <= DEPTH_WORD;
            out_avail_q <= '0;
            led_q       <= '1;
            test_q      <= '0;
        end else begin
            in_avail_q  <= in_avail_d;
            out_avail_q <= out_avail_d;
            led_q       <= led_d;
            test_q      <= test_d;
        end
    end

    assign ti_in_available  = in_avail_q;
    assign ti_out_available = out_avail_q;
    assign a_led            = led_q;
    assign ti_out_data      = fifo_rd_data;
    assign ti_out_test      = test_q;

endmodule

// File: tb/tb_xem6010_template_project_core.sv
// Directed self-checking bench for the XEM6010 host-loopback template core.
module tb_xem6010_template_project_core;

    logic        ti_clk = 1'b0;
    logic        s_clk = 1'b0;
    logic        ti_rst_soft;
    logic        a_rst_hard;
    logic [7:0]  a_led;
    logic [15:0] ti_in_available;
    logic        ti_in_data_en;
    logic [15:0] ti_in_data;
    logic [15:0] ti_out_available;
    logic        ti_out_data_en;
    logic [15:0] ti_out_data;
    logic        ti_in_test_en;
    logic [15:0] ti_in_test;
    logic        ti_out_test_en;
    logic [15:0] ti_out_test;

    int checks = 0;
    int failures = 0;

    always #5 ti_clk = ~ti_clk;
    always #7 s_clk = ~s_clk;

    xem6010_template_project_core dut (
        .ti_clk           (ti_clk),
        .ti_rst_soft      (ti_rst_soft),
        .a_rst_hard       (a_rst_hard),
        .s_clk            (s_clk),
        .a_led            (a_led),
        .ti_in_available  (ti_in_available),
        .ti_in_data_en    (ti_in_data_en),
        .ti_in_data       (ti_in_data),
        .ti_out_available (ti_out_available),
        .ti_out_data_en   (ti_out_data_en),
        .ti_out_data      (ti_out_data),
        .ti_in_test_en    (ti_in_test_en),
        .ti_in_test       (ti_in_test),
        .ti_out_test_en   (ti_out_test_en),
        .ti_out_test      (ti_out_test)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge ti_clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        ti_in_data_en  = 1'b0;
        ti_in_data     = 16'h0;
        ti_out_data_en = 1'b0;
        ti_in_test_en  = 1'b0;
        ti_in_test     = 16'h0;
        ti_out_test_en = 1'b0;
    endtask

    task automatic write_burst(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            ti_in_data_en = 1'b1;
            ti_in_data    = first + 16'(i);
            tick();
        end
        ti_in_data_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ti_rst_soft = 1'b0;
        a_rst_hard  = 1'b1;
        tick(5);
        a_rst_hard  = 1'b0;
        tick(3);
        ti_rst_soft = 1'b1;
        tick(5);
        ti_rst_soft = 1'b0;
        tick();
        checks++;
        if (ti_in_available !== 16'd16) begin
            failures++;
            $display("[TB] FAIL reset_in_available: got %0d expected 16", ti_in_available);
        end
        checks++;
        if (ti_out_available !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_out_available: got %0d expected 0", ti_out_available);
        end
        checks++;
        if (a_led !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL reset_led: got %h expected ff", a_led);
        end
        checks++;
        if (ti_out_data !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_out_data: got %h expected 0000", ti_out_data);
        end
        checks++;
        if (ti_out_test !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_out_test: got %h expected 0000", ti_out_test);
        end
    endtask

    task automatic test_fill();
        write_burst(16'd1, 10);
        tick(2);
        checks++;
        if (ti_out_available !== 16'd10) begin
            failures++;
            $display("[TB] FAIL fill_out_available: got %0d expected 10", ti_out_available);
        end
        checks++;
        if (ti_in_available !== 16'd6) begin
            failures++;
            $display("[TB] FAIL fill_in_available: got %0d expected 6", ti_in_available);
        end
        checks++;
        if (a_led !== 8'hF5) begin
            failures++;
            $display("[TB] FAIL fill_led: got %h expected f5", a_led);
        end
        checks++;
        if (ti_out_data !== 16'd1) begin
            failures++;
            $display("[TB] FAIL fill_head: got %h expected 0001", ti_out_data);
        end
    endtask

    task automatic test_drain();
        logic [15:0] exp;
        for (int i = 0; i < 16; i++) begin
            exp = (i < 10) ? 16'(i + 1) : 16'h0;
            ti_out_data_en = 1'b1;
            checks++;
            if (ti_out_data !== exp) begin
                failures++;
                $display("[TB] FAIL drain_data[%0d]: got %h expected %h", i, ti_out_data, exp);
            end
            tick();
        end
        ti_out_data_en = 1'b0;
        tick(2);
        checks++;
        if (ti_out_available !== 16'd0) begin
            failures++;
            $display("[TB] FAIL drain_out_available: got %0d expected 0", ti_out_available);
        end
        checks++;
        if (ti_in_available !== 16'd16) begin
            failures++;
            $display("[TB] FAIL drain_in_available: got %0d expected 16", ti_in_available);
        end
        checks++;
        if (ti_out_data !== 16'h0) begin
            failures++;
            $display("[TB] FAIL drain_empty_data: got %h expected 0000", ti_out_data);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp;
        write_burst(16'd1, 20);
        tick(2);
        checks++;
        if (ti_in_available !== 16'd0) begin
            failures++;
            $display("[TB] FAIL overflow_in_available: got %0d expected 0", ti_in_available);
        end
        checks++;
        if (ti_out_available !== 16'd16) begin
            failures++;
            $display("[TB] FAIL overflow_out_available: got %0d expected 16", ti_out_available);
        end
        checks++;
        if (a_led !== 8'hEF) begin
            failures++;
            $display("[TB] FAIL overflow_led: got %h expected ef", a_led);
        end
        for (int i = 0; i < 16; i++) begin
            exp = 16'(i + 1);
            ti_out_data_en = 1'b1;
            checks++;
            if (ti_out_data !== exp) begin
                failures++;
                $display("[TB] FAIL overflow_data[%0d]: got %h expected %h", i, ti_out_data, exp);
            end
            tick();
        end
        ti_out_data_en = 1'b0;
        tick(2);
        checks++;
        if (ti_out_available !== 16'd0 || ti_out_data !== 16'h0) begin
            failures++;
            $display("[TB] FAIL overflow_after_drain: got count %0d data %h expected count 0 data 0000",
                     ti_out_available, ti_out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        write_burst(16'd100, 12);
        for (int i = 0; i < 8; i++) begin
            exp = 16'(100 + i);
            ti_out_data_en = 1'b1;
            checks++;
            if (ti_out_data !== exp) begin
                failures++;
                $display("[TB] FAIL wrap_read[%0d]: got %h expected %h", i, ti_out_data, exp);
            end
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            exp = 16'(108 + i);
            ti_in_data_en  = 1'b1;
            ti_in_data     = 16'(112 + i);
            ti_out_data_en = 1'b1;
            checks++;
            if (ti_out_data !== exp) begin
                failures++;
                $display("[TB] FAIL concurrent_read[%0d]: got %h expected %h", i, ti_out_data, exp);
            end
            tick();
        end
        ti_in_data_en  = 1'b0;
        ti_out_data_en = 1'b0;
        tick(2);
        checks++;
        if (ti_out_available !== 16'd4) begin
            failures++;
            $display("[TB] FAIL concurrent_count: got %0d expected 4", ti_out_available);
        end
        checks++;
        if (ti_in_available !== 16'd12) begin
            failures++;
            $display("[TB] FAIL concurrent_in_available: got %0d expected 12", ti_in_available);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 16'(118 + i);
            ti_out_data_en = 1'b1;
            checks++;
            if (ti_out_data !== exp) begin
                failures++;
                $display("[TB] FAIL wrap_tail[%0d]: got %h expected %h", i, ti_out_data, exp);
            end
            tick();
        end
        ti_out_data_en = 1'b0;
        tick(2);
    endtask

    task automatic test_empty_write_read();
        ti_in_data_en  = 1'b1;
        ti_in_data     = 16'h1234;
        ti_out_data_en = 1'b1;
        tick();
        ti_in_data_en  = 1'b0;
        ti_out_data_en = 1'b0;
        tick();
        checks++;
        if (ti_out_available !== 16'd1 || ti_out_data !== 16'h1234) begin
            failures++;
            $display("[TB] FAIL empty_wr_rd: got count %0d data %h expected count 1 data 1234",
                     ti_out_available, ti_out_data);
        end
        ti_out_data_en = 1'b1;
        tick();
        ti_out_data_en = 1'b0;
        tick(2);
    endtask

    task automatic test_test_reg();
        ti_in_test_en = 1'b1;
        ti_in_test    = 16'hA5C3;
        tick();
        ti_in_test_en  = 1'b0;
        ti_in_test     = 16'hFFFF;
        ti_out_test_en = 1'b1;
        tick();
        ti_out_test_en = 1'b0;
        checks++;
        if (ti_out_test !== 16'hA5C3) begin
            failures++;
            $display("[TB] FAIL test_reg_write: got %h expected a5c3", ti_out_test);
        end
        ti_rst_soft = 1'b1;
        tick();
        ti_rst_soft = 1'b0;
        tick();
        checks++;
        if (ti_out_test !== 16'h0) begin
            failures++;
            $display("[TB] FAIL test_reg_reset: got %h expected 0000", ti_out_test);
        end
    endtask

    task automatic test_reset_mid_transfer();
        write_burst(16'h0A0A, 3);
        ti_rst_soft    = 1'b1;
        ti_in_data_en  = 1'b1;
        ti_in_data     = 16'h7777;
        ti_out_data_en = 1'b1;
        tick();
        ti_rst_soft    = 1'b0;
        ti_in_data_en  = 1'b0;
        ti_out_data_en = 1'b0;
        checks++;
        if (ti_out_available !== 16'd0 || ti_out_data !== 16'h0) begin
            failures++;
            $display("[TB] FAIL mid_reset_empty: got count %0d data %h expected count 0 data 0000",
                     ti_out_available, ti_out_data);
        end
        write_burst(16'h0055, 1);
        tick();
        checks++;
        if (ti_out_data !== 16'h0055 || ti_in_available !== 16'd15) begin
            failures++;
            $display("[TB] FAIL mid_reset_restart: got data %h free %0d expected data 0055 free 15",
                     ti_out_data, ti_in_available);
        end
        write_burst(16'h0B0B, 2);
        a_rst_hard = 1'b1;
        tick(5);
        a_rst_hard = 1'b0;
        tick(3);
        checks++;
        if (ti_out_available !== 16'd0 || a_led !== 8'hFF || ti_out_data !== 16'h0) begin
            failures++;
            $display("[TB] FAIL hard_reset_button: got count %0d led %h data %h expected 0 ff 0000",
                     ti_out_available, a_led, ti_out_data);
        end
    endtask

    initial begin
        idle_inputs();
        ti_rst_soft = 1'b0;
        a_rst_hard  = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_overflow();
        test_back_to_back();
        test_empty_write_read();
        test_test_reg();
        test_reset_mid_transfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
